// File: rtl/cpu_pkg.sv
// Shared types for the ALU issue/writeback slice: opcodes, sequencer states,
// instruction layout and the opcode legality check.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_ADC   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_SBB   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_NOT   = 4'b0111,
        OP_SHL   = 4'b1000,
        OP_SHR   = 4'b1001,
        OP_RSV_A = 4'b1010,
        OP_ROR   = 4'b1011,
        OP_RSV_C = 4'b1100,
        OP_RSV_D = 4'b1101,
        OP_RSV_E = 4'b1110,
        OP_RSV_F = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef struct packed {
        alu_op_e     op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        imm_sel;
        logic [2:0]  rt;
        logic [1:0]  reserved;
        logic [7:0]  imm8;
    } instr_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal_s;
        case (op)
            4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111: legal_s = 1'b0;
            default:                                     legal_s = 1'b1;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x8 general-purpose register file: two operand read ports, one debug read
// port, one synchronous write port; synchronous reset clears every entry.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] rs_addr,
    input  logic [2:0] rt_addr,
    input  logic [2:0] dbg_addr,
    output logic [7:0] rs_data,
    output logic [7:0] rt_data,
    output logic [7:0] dbg_data,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] mem_r [8];

    // Storage: clear on reset, otherwise single write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = mem_r[rs_addr];
    assign rt_data  = mem_r[rt_addr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback sequencer around the external combinational 8-bit ALU:
// accept, read operands, execute, write back, one instruction per 4 cycles.
module alu_issue_wb
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [23:0] instr_i,
    output logic        instr_ready_o,
    output logic [7:0]  alu_rs_o,
    output logic [7:0]  alu_op2_o,
    output logic [2:0]  alu_count_o,
    output logic        alu_carry_o,
    output logic [3:0]  alu_op_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_carry_i,
    input  logic        alu_zero_i,
    output logic        carry_flag_o,
    output logic        zero_flag_o,
    output logic        done_o,
    output logic        illegal_o,
    input  logic [2:0]  dbg_addr_i,
    output logic [7:0]  dbg_data_o
);

    state_e     state_r, state_nxt_s;
    instr_t     instr_s;
    logic       accept_s, wb_en_s;
    logic [7:0] rs_data_s, rt_data_s;
    logic [7:0] rs_r, op2_r;
    logic [2:0] count_r, rd_r;
    logic       cin_r, illegal_r;
    logic [3:0] op_r;
    logic       carry_r, zero_r;
    logic       ready_r, done_r, illegal_pulse_r;

    assign instr_s  = instr_t'(instr_i);
    assign accept_s = instr_valid_i & ready_r;
    assign wb_en_s  = (state_r == WB) & ~illegal_r;

    // Operands are read straight from the incoming word on the accepting edge,
    // so the ALU inputs are already valid throughout READ, EXEC and WB.
    cpu_regfile u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rs_addr  (instr_s.rs),
        .rt_addr  (instr_s.rt),
        .dbg_addr (dbg_addr_i),
        .rs_data  (rs_data_s),
        .rt_data  (rt_data_s),
        .dbg_data (dbg_data_o),
        .wr_en    (wb_en_s),
        .wr_addr  (rd_r),
        .wr_data  (alu_res_i)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ:    state_nxt_s = EXEC;
            EXEC:    state_nxt_s = WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered handshake and retire pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= IDLE;
            ready_r         <= 1'b1;
            done_r          <= 1'b0;
            illegal_pulse_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            ready_r         <= (state_nxt_s == IDLE);
            done_r          <= (state_r == EXEC);
            illegal_pulse_r <= (state_r == EXEC) & illegal_r;
        end
    end

    // Operand registers hold from one accept to the next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs_r      <= 8'h00;
            op2_r     <= 8'h00;
            count_r   <= 3'd0;
            cin_r     <= 1'b0;
            op_r      <= 4'h0;
            illegal_r <= 1'b0;
            rd_r      <= 3'd0;
        end else if (accept_s) begin
            rs_r      <= rs_data_s;
            op2_r     <= instr_s.imm_sel ? instr_s.imm8 : rt_data_s;
            count_r   <= instr_s.imm8[2:0];
            cin_r     <= carry_r;
            op_r      <= instr_s.op;
            illegal_r <= ~is_legal_op(instr_s.op);
            rd_r      <= instr_s.rd;
        end
    end

    // Flag writeback; logic ops (op[2] set) keep the previous carry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (wb_en_s) begin
            zero_r <= alu_zero_i;
            if (!op_r[2]) begin
                carry_r <= alu_carry_i;
            end
        end
    end

    assign instr_ready_o = ready_r;
    assign alu_rs_o      = rs_r;
    assign alu_op2_o     = op2_r;
    assign alu_count_o   = count_r;
    assign alu_carry_o   = cin_r;
    assign alu_op_o      = op_r;
    assign carry_flag_o  = carry_r;
    assign zero_flag_o   = zero_r;
    assign done_o        = done_r;
    assign illegal_o     = illegal_pulse_r;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: directed scenarios then random
// instructions, checked against an architectural register/flag model.
module tb_alu_issue_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic [23:0] instr_i;
    logic        instr_ready_o;
    logic [7:0]  alu_rs_o, alu_op2_o;
    logic [2:0]  alu_count_o;
    logic        alu_carry_o;
    logic [3:0]  alu_op_o;
    logic [7:0]  alu_res_i;
    logic        alu_carry_i, alu_zero_i;
    logic        carry_flag_o, zero_flag_o, done_o, illegal_o;
    logic [2:0]  dbg_addr_i;
    logic [7:0]  dbg_data_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mreg [8];
    logic       mcarry, mzero;

    alu_issue_wb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
        .alu_rs_o(alu_rs_o), .alu_op2_o(alu_op2_o), .alu_count_o(alu_count_o),
        .alu_carry_o(alu_carry_o), .alu_op_o(alu_op_o),
        .alu_res_i(alu_res_i), .alu_carry_i(alu_carry_i), .alu_zero_i(alu_zero_i),
        .carry_flag_o(carry_flag_o), .zero_flag_o(zero_flag_o),
        .done_o(done_o), .illegal_o(illegal_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU: returns {carry, result}. Logic ops return ~cin as carry
    // so that a wrongly updated carry flag is visible.
    function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [2:0] cnt,
                                           input logic cin);
        logic [8:0] r;
        logic [7:0] rot;
        int c;
        c = int'(cnt);
        case (op)
            4'd0:  r = {1'b0, a} + {1'b0, b};
            4'd1:  r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd2:  r = {1'b0, a} - {1'b0, b};
            4'd3:  r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            4'd4:  r = {~cin, a & b};
            4'd5:  r = {~cin, a | b};
            4'd6:  r = {~cin, a ^ b};
            4'd7:  r = {~cin, ~a};
            4'd8:  r = {1'b0, a} << c;
            4'd9:  begin
                       r = {1'b0, a, 1'b0} >> c;
                       r = {r[0], r[8:1]};
                   end
            4'd11: begin
                       rot = (a >> c) | (a << (8 - c));
                       r = {rot[7], rot};
                   end
            default: r = {1'b1, a ^ b};
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_carry_i, alu_res_i} = ref_alu(alu_op_o, alu_rs_o, alu_op2_o, alu_count_o, alu_carry_o);
        alu_zero_i = (alu_res_i == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic sel,
                                       input logic [2:0] rt, input logic [7:0] imm);
        return {op, rd, rs, sel, rt, 2'b11, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        mcarry = 1'b0;
        mzero  = 1'b0;
    endtask

    task automatic model_exec(input logic [23:0] w);
        logic [3:0] op;
        logic [7:0] a, b;
        logic [8:0] r;
        op = w[23:20];
        a  = mreg[w[16:14]];
        b  = w[13] ? w[7:0] : mreg[w[12:10]];
        r  = ref_alu(op, a, b, w[2:0], mcarry);
        if (op <= 4'd9 || op == 4'd11) begin
            mreg[w[19:17]] = r[7:0];
            mzero = (r[7:0] == 8'h00);
            if (op < 4'd4 || op >= 4'd8) mcarry = r[8];
        end
    endtask

    // One full instruction, starting with the bench at a negedge before cycle 0.
    task automatic issue(input logic [23:0] w);
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] ea, eb, old;
        logic       ecin, legal;
        op    = w[23:20];
        rd    = w[19:17];
        ea    = mreg[w[16:14]];
        eb    = w[13] ? w[7:0] : mreg[w[12:10]];
        ecin  = mcarry;
        legal = (op <= 4'd9 || op == 4'd11);
        old   = mreg[rd];
        @(negedge clk_i);
        check("ready_c0", instr_ready_o, 1);
        instr_valid_i = 1'b1;
        instr_i = w;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        instr_i = 24'($urandom());
        dbg_addr_i = rd;
        check("ready_c1", instr_ready_o, 0);
        check("done_c1", done_o, 0);
        check("alu_rs", alu_rs_o, ea);
        check("alu_op2", alu_op2_o, eb);
        check("alu_count", alu_count_o, w[2:0]);
        check("alu_cin_c1", alu_carry_o, ecin);
        check("alu_op", alu_op_o, op);
        @(negedge clk_i);
        check("ready_c2", instr_ready_o, 0);
        check("done_c2", done_o, 0);
        check("alu_cin_c2", alu_carry_o, ecin);
        @(negedge clk_i);
        check("done_c3", done_o, 1);
        check("illegal_c3", illegal_o, !legal);
        check("ready_c3", instr_ready_o, 0);
        check("dbg_old_c3", dbg_data_o, old);
        check("alu_cin_c3", alu_carry_o, ecin);
        model_exec(w);
        @(negedge clk_i);
        check("done_c4", done_o, 0);
        check("illegal_c4", illegal_o, 0);
        check("ready_c4", instr_ready_o, 1);
        check("dbg_new_c4", dbg_data_o, mreg[rd]);
        check("carry_flag", carry_flag_o, mcarry);
        check("zero_flag", zero_flag_o, mzero);
    endtask

    initial begin
        rst_i = 1'b1;
        instr_valid_i = 1'b0;
        instr_i = 24'h0;
        dbg_addr_i = 3'd0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", instr_ready_o, 1);
        check("rst_done", done_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_carry", carry_flag_o, 0);
        check("rst_zero", zero_flag_o, 0);
        check("rst_alu_op", alu_op_o, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            check("rst_reg", dbg_data_o, 0);
        end

        // Immediate add, carry/zero, logic op, carry-in, shift, illegal
        issue(mk(4'd0, 3'd1, 3'd0, 1'b1, 3'd0, 8'h05));
        issue(mk(4'd5, 3'd1, 3'd0, 1'b1, 3'd0, 8'hFF));
        issue(mk(4'd0, 3'd2, 3'd1, 1'b1, 3'd0, 8'h01));
        check("cz_carry", carry_flag_o, 1);
        check("cz_zero", zero_flag_o, 1);
        issue(mk(4'd4, 3'd4, 3'd1, 1'b1, 3'd0, 8'h0F));
        check("logic_res", dbg_data_o, 8'h0F);
        check("logic_carry_kept", carry_flag_o, 1);
        issue(mk(4'd1, 3'd5, 3'd4, 1'b1, 3'd0, 8'h10));
        issue(mk(4'd8, 3'd6, 3'd4, 1'b1, 3'd0, 8'h03));
        issue(mk(4'd12, 3'd3, 3'd1, 1'b0, 3'd2, 8'hAA));

        // Handshake: valid held high for 12 cycles
        begin
            int accepts;
            logic [23:0] w;
            accepts = 0;
            w = mk(4'd0, 3'd5, 3'd5, 1'b1, 3'd0, 8'h01);
            @(negedge clk_i);
            instr_valid_i = 1'b1;
            instr_i = w;
            for (int i = 0; i < 12; i++) begin
                check("hs_ready", instr_ready_o, (i % 4) == 0);
                check("hs_done", done_o, (i % 4) == 3);
                if (instr_ready_o) accepts++;
                if ((i % 4) == 3) model_exec(w);
                @(negedge clk_i);
            end
            instr_valid_i = 1'b0;
            check("hs_accepts", accepts, 3);
            dbg_addr_i = 3'd5;
            #1;
            check("hs_r5", dbg_data_o, mreg[5]);
        end

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            issue(24'($urandom()));
        end

        // Reset in EXEC aborts the instruction
        @(negedge clk_i);
        instr_valid_i = 1'b1;
        instr_i = mk(4'd0, 3'd6, 3'd0, 1'b1, 3'd0, 8'h33);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_done", done_o, 0);
        check("abort_ready", instr_ready_o, 1);
        @(negedge clk_i);
        dbg_addr_i = 3'd6;
        #1;
        check("abort_done2", done_o, 0);
        check("abort_r6", dbg_data_o, mreg[6]);
        check("abort_carry", carry_flag_o, mcarry);
        issue(mk(4'd0, 3'd6, 3'd0, 1'b1, 3'd0, 8'h44));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
